xor_stream_ctrl: RTL and testbench

SPI-slave controller that sequences the XOR encryption datapath: it decodes a command byte per chip-select frame, loads or reads back the 8-bit XOR key, and streams data bytes through the XOR, presenting each ciphertext byte both on a parallel strobe port and on MISO one byte later. It sits between the chip's SPI pins and the XOR datapath/output pins, and owns the key register feeding the datapath.

---
 rtl/xor_stream_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_xor_stream_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : xor_stream_ctrl                                            |
// | Description : SPI-slave (mode 0) controller for the XOR datapath.        |
// |               Each chip-select frame starts with a command byte that     |
// |               writes the key, streams data through the XOR (parallel     |
// |               strobe plus MISO echo one byte later) or reads back the    |
// |               key.                                                       |
// | Options     : XOR_ROLLING_KEY_EN - rotate the key left by one bit after  |
// |               every streamed byte.                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module xor_stream_ctrl #(
   parameter logic [7:0] DEFAULT_KEY = 8'hBE,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_sck,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic [7:0] par_data,
   output logic       par_valid,
   output logic [7:0] key_out,
   output logic       busy,
   output logic       err
);

   localparam logic [7:0] CMD_WKEY = 8'h01;
   localparam logic [7:0] CMD_XFER = 8'h02;
   localparam logic [7:0] CMD_RKEY = 8'h03;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_WKEY    = 3'd2,
      ST_XFER    = 3'd3,
      ST_RKEY    = 3'd4,
      ST_SKIP    = 3'd5,
      ST_WAIT_CS = 3'd6
   } state_t;

   // Synchronizer chains and edge-detect history
   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sck_prev_q;
   logic                   cs_prev_q;

   // Control and datapath registers
   state_t     state_q,     state_d;
   logic [2:0] bit_cnt_q,   bit_cnt_d;
   logic [7:0] rx_q,        rx_d;
   logic [7:0] tx_q,        tx_d;
   logic [7:0] key_q,       key_d;
   logic [7:0] par_data_q,  par_data_d;
   logic       par_valid_q, par_valid_d;
   logic       err_q,       err_d;

   logic       w_sck;
   logic       w_cs_n;
   logic       w_mosi;
   logic       w_sck_rise;
   logic       w_sck_fall;
   logic       w_cs_fall;
   logic       w_cs_rise;
   logic       w_in_frame;
   logic [7:0] w_rx_byte;
   logic [7:0] w_cipher;

   // Input synchronizers; left unreset so a chip select held low across reset
   // is seen as a level (-> WAIT_CS) rather than as a fresh falling edge.
   always_ff @(posedge clk) begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
   end

   assign w_sck      = sck_sync_q[SYNC_STAGES-1];
   assign w_cs_n     = cs_sync_q[SYNC_STAGES-1];
   assign w_mosi     = mosi_sync_q[SYNC_STAGES-1];
   assign w_sck_rise =  w_sck & ~sck_prev_q;
   assign w_sck_fall = ~w_sck &  sck_prev_q;
   assign w_cs_fall  = ~w_cs_n &  cs_prev_q;
   assign w_cs_rise  =  w_cs_n & ~cs_prev_q;

   assign w_in_frame = (state_q != ST_IDLE) && (state_q != ST_WAIT_CS);
   assign w_rx_byte  = {rx_q[6:0], w_mosi};
   assign w_cipher   = w_rx_byte ^ key_q;

   // Frame sequencing: command decode, byte assembly and MISO shifting
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      key_d       = key_q;
      par_data_d  = par_data_q;
      par_valid_d = 1'b0;
      err_d       = err_q;

      case (state_q)
         ST_IDLE: begin
            if (w_cs_fall) begin
               state_d   = ST_CMD;
               bit_cnt_d = 3'd0;
               rx_d      = 8'h00;
               err_d     = 1'b0;
               tx_d      = {7'b0, err_q};
            end else if (!w_cs_n) begin
               // Chip select already low without an edge: only after reset.
               state_d = ST_WAIT_CS;
            end
         end

         ST_WAIT_CS: begin
            if (w_cs_n) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            if (w_cs_rise) begin
               // End of frame wins over any coincident sck edge.
               state_d   = ST_IDLE;
               bit_cnt_d = 3'd0;
            end else if (w_sck_rise) begin
               rx_d      = w_rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  tx_d = 8'h00;
                  case (state_q)
                     ST_CMD: begin
                        if (w_rx_byte == CMD_WKEY) begin
                           state_d = ST_WKEY;
                        end else if (w_rx_byte == CMD_XFER) begin
                           state_d = ST_XFER;
                        end else if (w_rx_byte == CMD_RKEY) begin
                           state_d = ST_RKEY;
                           tx_d    = key_q;
                        end else begin
                           state_d = ST_SKIP;
                           err_d   = 1'b1;
                        end
                     end
                     ST_WKEY: begin
                        key_d   = w_rx_byte;
                        state_d = ST_SKIP;
                     end
                     ST_XFER: begin
                        par_data_d  = w_cipher;
                        par_valid_d = 1'b1;
                        tx_d        = w_cipher;
`ifdef XOR_ROLLING_KEY_EN
                        key_d       = {key_q[6:0], key_q[7]};
`endif
                     end
                     ST_RKEY: begin
                        state_d = ST_SKIP;
                     end
                     default: begin
                        // SKIP: byte discarded
                     end
                  endcase
               end
            end else if (w_sck_fall) begin
               // At a byte boundary the freshly loaded MSB is already on MISO.
               if (bit_cnt_q != 3'd0) begin
                  tx_d = {tx_q[6:0], 1'b0};
               end
            end
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         rx_q        <= 8'h00;
         tx_q        <= 8'h00;
         key_q       <= DEFAULT_KEY;
         par_data_q  <= 8'h00;
         par_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         key_q       <= key_d;
         par_data_q  <= par_data_d;
         par_valid_q <= par_valid_d;
         err_q       <= err_d;
      end
   end

   assign spi_miso  = w_in_frame & tx_q[7];
   assign par_data  = par_data_q;
   assign par_valid = par_valid_q;
   assign key_out   = key_q;
   assign busy      = w_in_frame;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_xor_stream_ctrl                                         |
// | Description : Frame-level reference model, per-cycle strobe monitor,     |
// |               directed and randomized SPI frames for xor_stream_ctrl.    |
// |               Honours XOR_ROLLING_KEY_EN when defined.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_xor_stream_ctrl;

   localparam logic [7:0] DEF_KEY = 8'hBE;
   localparam int         HP      = 6;   // sck half period in clk cycles

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       sck   = 1'b0;
   logic       cs_n  = 1'b1;
   logic       mosi  = 1'b0;
   logic       miso;
   logic [7:0] par_data;
   logic       par_valid;
   logic [7:0] key_out;
   logic       busy;
   logic       err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [7:0] m_key = DEF_KEY;
   logic       m_err = 1'b0;
   logic [7:0] exp_par_q[$];
   logic [7:0] seen_par[$];
   logic       pv_prev = 1'b0;

   // Frame buffers
   logic [7:0] f_tx[8];
   logic [7:0] f_rx[8];
   logic [7:0] e_miso[8];
   logic       e_chk[8];

   xor_stream_ctrl #(
      .DEFAULT_KEY (DEF_KEY),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_sck   (sck),
      .spi_cs_n  (cs_n),
      .spi_mosi  (mosi),
      .spi_miso  (miso),
      .par_data  (par_data),
      .par_valid (par_valid),
      .key_out   (key_out),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] next_key(input logic [7:0] k);
`ifdef XOR_ROLLING_KEY_EN
      return {k[6:0], k[7]};
`else
      return k;
`endif
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle strobe monitor: every par_valid must match the next expected byte
   always @(negedge clk) begin
      if (par_valid) begin
         n_tests++;
         seen_par.push_back(par_data);
         if (pv_prev) begin
            n_fail++;
            $display("FAIL par_valid_consecutive: got two strobes, expected one");
         end else if (exp_par_q.size() == 0) begin
            n_fail++;
            $display("FAIL par_valid_unexpected: got par_data 0x%0h, expected no strobe", par_data);
         end else begin
            logic [7:0] e;
            e = exp_par_q.pop_front();
            if (par_data !== e) begin
               n_fail++;
               $display("FAIL par_data: got 0x%0h expected 0x%0h", par_data, e);
            end
         end
      end
      pv_prev = par_valid;
   end

   // Shift nb bits of b (MSB first), capturing MISO just before each rising edge
   task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
      r = 8'h00;
      for (int i = 0; i < nb; i++) begin
         mosi = b[7-i];
         wait_clk(HP);
         r[7-i] = miso;
         sck = 1'b1;
         wait_clk(HP);
         sck = 1'b0;
      end
   endtask

   // Frame-level model: derive expected strobes, MISO bytes, key and err
   task automatic model_frame(input int nbits);
      int         nfull;
      logic [7:0] ct;
      nfull = nbits / 8;
      for (int k = 0; k < 8; k++) begin
         e_chk[k]  = 1'b0;
         e_miso[k] = 8'h00;
      end
      e_miso[0] = {7'b0, m_err};
      e_chk[0]  = (nfull >= 1);
      m_err     = 1'b0;
      if (nfull >= 1) begin
         case (f_tx[0])
            8'h01: if (nfull >= 2) m_key = f_tx[1];
            8'h02: begin
               if (nfull >= 2) e_chk[1] = 1'b1;
               for (int k = 1; k < nfull; k++) begin
                  ct = f_tx[k] ^ m_key;
                  exp_par_q.push_back(ct);
                  if (k + 1 < nfull) begin
                     e_miso[k+1] = ct;
                     e_chk[k+1]  = 1'b1;
                  end
                  m_key = next_key(m_key);
               end
            end
            8'h03: begin
               for (int k = 1; k < nfull; k++) begin
                  e_miso[k] = (k == 1) ? m_key : 8'h00;
                  e_chk[k]  = 1'b1;
               end
            end
            default: m_err = 1'b1;
         endcase
      end
   endtask

   task automatic run_frame(input int nbits);
      int rem;
      int nb;
      model_frame(nbits);
      cs_n = 1'b0;
      wait_clk(HP);
      check("busy_in_frame", busy, 1);
      check("err_clear_on_cs", err, 0);
      rem = nbits;
      for (int k = 0; k < 8 && rem > 0; k++) begin
         nb = (rem > 8) ? 8 : rem;
         spi_bits(f_tx[k], nb, f_rx[k]);
         rem -= nb;
      end
      wait_clk(HP);
      cs_n = 1'b1;
      wait_clk(HP + 2);
      for (int k = 0; k < 8; k++) begin
         if (e_chk[k]) check($sformatf("miso_byte%0d", k), f_rx[k], e_miso[k]);
      end
      check("par_outstanding", exp_par_q.size(), 0);
      exp_par_q.delete();
      check("key_out", key_out, m_key);
      check("err", err, m_err);
      check("busy_idle", busy, 0);
   endtask

   initial begin
      logic [7:0] r;
      int         nbytes;
      int         nbits;
      int         sel;

      wait_clk(10);
      rst_n = 1'b1;
      wait_clk(2);
      check("rst_key", key_out, 8'hBE);
      check("rst_par_data", par_data, 0);
      check("rst_par_valid", par_valid, 0);
      check("rst_miso", miso, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);

      // Key readback after reset
      f_tx[0] = 8'h03; f_tx[1] = 8'h00;
      run_frame(16);
      check("lit_rkey_status", f_rx[0], 8'h00);
      check("lit_rkey_key", f_rx[1], 8'hBE);

      // Streaming with the default key
      seen_par.delete();
      f_tx[0] = 8'h02; f_tx[1] = 8'h00; f_tx[2] = 8'hFF; f_tx[3] = 8'h41;
      run_frame(32);
      check("lit_xfer_count", seen_par.size(), 3);
      if (seen_par.size() == 3) begin
         check("lit_xfer_ct0", seen_par[0], 8'hBE);
`ifdef XOR_ROLLING_KEY_EN
         check("lit_xfer_ct1", seen_par[1], 8'h82);
`else
         check("lit_xfer_ct1", seen_par[1], 8'h41);
         check("lit_xfer_ct2", seen_par[2], 8'hFF);
         check("lit_xfer_miso3", f_rx[3], 8'h41);
`endif
      end
      check("lit_xfer_miso1", f_rx[1], 8'h00);
      check("lit_xfer_miso2", f_rx[2], 8'hBE);

      // Key write, then stream with the new key, then read it back
      f_tx[0] = 8'h01; f_tx[1] = 8'h5A;
      run_frame(16);
      check("lit_wkey_key", key_out, 8'h5A);
      seen_par.delete();
      f_tx[0] = 8'h02; f_tx[1] = 8'h5A;
      run_frame(16);
      check("lit_wkey_ct", par_data, 8'h00);
      f_tx[0] = 8'h03; f_tx[1] = 8'h00;
      run_frame(16);
`ifndef XOR_ROLLING_KEY_EN
      check("lit_wkey_readback", f_rx[1], 8'h5A);
`endif

      // Unknown command sets err; next status byte reports it
      f_tx[0] = 8'h7E; f_tx[1] = 8'h11;
      run_frame(16);
      check("lit_err_set", err, 1);
      f_tx[0] = 8'h03; f_tx[1] = 8'h00;
      run_frame(16);
      check("lit_err_status", f_rx[0], 8'h01);

      // Aborted key write: 5 bits of the key byte
      f_tx[0] = 8'h01; f_tx[1] = 8'hA5;
      run_frame(13);

      // Reset in the middle of a streaming frame with cs_n held low
      m_err = 1'b0;
      cs_n = 1'b0;
      wait_clk(HP);
      spi_bits(8'h02, 8, r);
      exp_par_q.push_back(8'h33 ^ m_key);
      m_key = next_key(m_key);
      spi_bits(8'h33, 8, r);
      spi_bits(8'hC3, 4, r);
      check("mid_par_consumed", exp_par_q.size(), 0);
      wait_clk(2);
      rst_n = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      m_key = DEF_KEY;
      m_err = 1'b0;
      wait_clk(2);
      check("mid_rst_key", key_out, 8'hBE);
      check("mid_rst_par_data", par_data, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_miso", miso, 0);
      spi_bits(8'h02, 8, r);
      spi_bits(8'h55, 8, r);
      check("wait_cs_miso", r, 0);
      check("wait_cs_busy", busy, 0);
      check("wait_cs_key", key_out, 8'hBE);
      cs_n = 1'b1;
      wait_clk(HP + 2);
      f_tx[0] = 8'h02; f_tx[1] = 8'h12; f_tx[2] = 8'h34;
      run_frame(24);

      // Randomized frames
      for (int t = 0; t < 40; t++) begin
         sel = $urandom_range(0, 9);
         for (int k = 0; k < 8; k++) f_tx[k] = 8'($urandom);
         if (sel < 3)       f_tx[0] = 8'h01;
         else if (sel < 6)  f_tx[0] = 8'h02;
         else if (sel < 8)  f_tx[0] = 8'h03;
         nbytes = $urandom_range(1, 6);
         nbits  = nbytes * 8;
         if ($urandom_range(0, 4) == 0) nbits = $urandom_range(1, nbits - 1);
         run_frame(nbits);
         wait_clk($urandom_range(0, 5));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
